// File: rtl/ls_ex.sv
// Load/store execution unit: runs one memory access at a time and broadcasts
// extended load results on the LS CDB. Optional feature macro: LS_EX_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module ls_ex #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6,
    parameter logic [OPENUM_W-1:0] OPENUM_LB  = OPENUM_W'(11),
    parameter logic [OPENUM_W-1:0] OPENUM_LH  = OPENUM_W'(12),
    parameter logic [OPENUM_W-1:0] OPENUM_LW  = OPENUM_W'(13),
    parameter logic [OPENUM_W-1:0] OPENUM_LBU = OPENUM_W'(14),
    parameter logic [OPENUM_W-1:0] OPENUM_LHU = OPENUM_W'(15),
    parameter logic [OPENUM_W-1:0] OPENUM_SB  = OPENUM_W'(16),
    parameter logic [OPENUM_W-1:0] OPENUM_SH  = OPENUM_W'(17),
    parameter logic [OPENUM_W-1:0] OPENUM_SW  = OPENUM_W'(18)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena_from_lsb,
    input  logic [OPENUM_W-1:0] openum_from_lsb,
    input  logic [ADDR_W-1:0]   mem_addr_from_lsb,
    input  logic [DATA_W-1:0]   store_value_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_to_lsb,
    output logic                ena_to_memctrl,
    output logic                rw_flag_to_memctrl,
    output logic [ADDR_W-1:0]   addr_to_memctrl,
    output logic [2:0]          size_to_memctrl,
    output logic [DATA_W-1:0]   data_to_memctrl,
    input  logic                ok_flag_from_memctrl,
    input  logic [DATA_W-1:0]   data_from_memctrl,
    input  logic                commit_jump_flag_from_rob,
    output logic                valid_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic [DATA_W-1:0]   result_to_cdb,
    output logic                misalign_flag
);

    typedef enum logic {IDLE, WAIT_MEM} state_e;

    function automatic logic is_load(input logic [OPENUM_W-1:0] op);
        return (op == OPENUM_LB) || (op == OPENUM_LH) || (op == OPENUM_LW) ||
               (op == OPENUM_LBU) || (op == OPENUM_LHU);
    endfunction

    function automatic logic [2:0] op_bytes(input logic [OPENUM_W-1:0] op);
        if (op == OPENUM_LB || op == OPENUM_LBU || op == OPENUM_SB)
            return 3'd1;
        else if (op == OPENUM_LH || op == OPENUM_LHU || op == OPENUM_SH)
            return 3'd2;
        else
            return 3'd4;
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] v,
                                                    input logic [2:0] sz);
        case (sz)
            3'd1:    return {{(DATA_W-8){1'b0}}, v[7:0]};
            3'd2:    return {{(DATA_W-16){1'b0}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [OPENUM_W-1:0] op,
                                                 input logic [DATA_W-1:0] d);
        if (op == OPENUM_LB)
            return {{(DATA_W-8){d[7]}}, d[7:0]};
        else if (op == OPENUM_LH)
            return {{(DATA_W-16){d[15]}}, d[15:0]};
        else if (op == OPENUM_LBU)
            return {{(DATA_W-8){1'b0}}, d[7:0]};
        else if (op == OPENUM_LHU)
            return {{(DATA_W-16){1'b0}}, d[15:0]};
        else
            return d;
    endfunction

    state_e                state_q;
    logic [OPENUM_W-1:0]   op_q;
    logic [ROB_ID_W-1:0]   rob_id_q;
    logic                  mis_q;
    logic                  drop_q;
    logic                  mem_ena_q;
    logic                  rw_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [2:0]            size_q;
    logic [DATA_W-1:0]     mem_data_q;
    logic                  valid_q;
    logic [ROB_ID_W-1:0]   cdb_rob_q;
    logic [DATA_W-1:0]     result_q;
    logic                  misalign_q;

    logic                  in_load;
    logic [2:0]            in_bytes;
    logic                  in_mis;
    logic                  q_load;
    logic                  flush_drop;

    assign in_load    = is_load(openum_from_lsb);
    assign in_bytes   = op_bytes(openum_from_lsb);
    assign q_load     = is_load(op_q);
    // A flush seen in the completing cycle suppresses the result just like an earlier one.
    assign flush_drop = drop_q || commit_jump_flag_from_rob;

`ifdef LS_EX_MISALIGN_CHECK_EN
    assign in_mis = ((in_bytes == 3'd2) && mem_addr_from_lsb[0]) ||
                    ((in_bytes == 3'd4) && (mem_addr_from_lsb[1:0] != 2'b00));
`else
    assign in_mis = 1'b0;
`endif

    // Combinational so the buffer sees busy in the same cycle it issues.
    assign busy_to_lsb = (state_q != IDLE) || ena_from_lsb;

    // NOTE: every register, including the latched request, is reset so all outputs read 0 during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rob_id_q   <= '0;
            mis_q      <= 1'b0;
            drop_q     <= 1'b0;
            mem_ena_q  <= 1'b0;
            rw_q       <= 1'b0;
            mem_addr_q <= '0;
            size_q     <= '0;
            mem_data_q <= '0;
            valid_q    <= 1'b0;
            cdb_rob_q  <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge state.
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ena_from_lsb && !(in_load && commit_jump_flag_from_rob)) begin
                        op_q       <= openum_from_lsb;
                        rob_id_q   <= rob_id_from_lsb;
                        mis_q      <= in_mis;
                        drop_q     <= 1'b0;
                        mem_ena_q  <= !in_mis;
                        rw_q       <= !in_load;
                        mem_addr_q <= mem_addr_from_lsb;
                        size_q     <= in_bytes;
                        mem_data_q <= in_load ? '0 : size_mask(store_value_from_lsb, in_bytes);
                        misalign_q <= in_mis;
                        state_q    <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (mis_q || ok_flag_from_memctrl) begin
                        state_q   <= IDLE;
                        mem_ena_q <= 1'b0;
                        drop_q    <= 1'b0;
                        if (q_load && !flush_drop) begin
                            valid_q   <= 1'b1;
                            cdb_rob_q <= rob_id_q;
                            result_q  <= mis_q ? '0 : extend(op_q, data_from_memctrl);
                        end
                    end else if (commit_jump_flag_from_rob && q_load) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ena_to_memctrl     = mem_ena_q;
    assign rw_flag_to_memctrl = rw_q;
    assign addr_to_memctrl    = mem_addr_q;
    assign size_to_memctrl    = size_q;
    assign data_to_memctrl    = mem_data_q;
    assign valid_to_cdb       = valid_q;
    assign rob_id_to_cdb      = cdb_rob_q;
    assign result_to_cdb      = result_q;
    assign misalign_flag      = misalign_q;

endmodule

// File: tb/tb_ls_ex.sv
// Scoreboard bench for ls_ex: a driver pushes expectations, a memory responder
// answers requests, and monitors pop and compare memctrl, CDB and misalign traffic.
`timescale 1ns/1ps
module tb_ls_ex;

    localparam logic [5:0] OP_LB  = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LW  = 6'd13;
    localparam logic [5:0] OP_LBU = 6'd14;
    localparam logic [5:0] OP_LHU = 6'd15;
    localparam logic [5:0] OP_SB  = 6'd16;
    localparam logic [5:0] OP_SH  = 6'd17;
    localparam logic [5:0] OP_SW  = 6'd18;

    logic        clk;
    logic        rst;
    logic        ena_from_lsb;
    logic [5:0]  openum_from_lsb;
    logic [31:0] mem_addr_from_lsb;
    logic [31:0] store_value_from_lsb;
    logic [3:0]  rob_id_from_lsb;
    logic        busy_to_lsb;
    logic        ena_to_memctrl;
    logic        rw_flag_to_memctrl;
    logic [31:0] addr_to_memctrl;
    logic [2:0]  size_to_memctrl;
    logic [31:0] data_to_memctrl;
    logic        ok_flag_from_memctrl;
    logic [31:0] data_from_memctrl;
    logic        commit_jump_flag_from_rob;
    logic        valid_to_cdb;
    logic [3:0]  rob_id_to_cdb;
    logic [31:0] result_to_cdb;
    logic        misalign_flag;

    ls_ex dut (
        .clk                       (clk),
        .rst                       (rst),
        .ena_from_lsb              (ena_from_lsb),
        .openum_from_lsb           (openum_from_lsb),
        .mem_addr_from_lsb         (mem_addr_from_lsb),
        .store_value_from_lsb      (store_value_from_lsb),
        .rob_id_from_lsb           (rob_id_from_lsb),
        .busy_to_lsb               (busy_to_lsb),
        .ena_to_memctrl            (ena_to_memctrl),
        .rw_flag_to_memctrl        (rw_flag_to_memctrl),
        .addr_to_memctrl           (addr_to_memctrl),
        .size_to_memctrl           (size_to_memctrl),
        .data_to_memctrl           (data_to_memctrl),
        .ok_flag_from_memctrl      (ok_flag_from_memctrl),
        .data_from_memctrl         (data_from_memctrl),
        .commit_jump_flag_from_rob (commit_jump_flag_from_rob),
        .valid_to_cdb              (valid_to_cdb),
        .rob_id_to_cdb             (rob_id_to_cdb),
        .result_to_cdb             (result_to_cdb),
        .misalign_flag             (misalign_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic rw; logic [31:0] addr; logic [2:0] size; logic [31:0] data; } mem_exp_t;
    typedef struct { int unsigned lat; logic [31:0] rdata; } mem_rsp_t;
    typedef struct { logic [3:0] rob; logic [31:0] res; int unsigned when; } cdb_exp_t;

    mem_exp_t    mem_exp_q[$];
    mem_rsp_t    mem_rsp_q[$];
    cdb_exp_t    cdb_q[$];
    int unsigned mis_q[$];

    // Reference model: access width and load extension by plain arithmetic.
    function automatic bit is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ext(input logic [5:0] op, input logic [31:0] d);
        longint v;
        v = longint'(d);
        case (op)
            OP_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            OP_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            OP_LBU: v = v % 256;
            OP_LHU: v = v % 65536;
            default: ;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] trunc(input logic [31:0] d, input int b);
        longint m;
        longint r;
        m = longint'(1) << (8 * b);
        r = longint'(d) % m;
        return r[31:0];
    endfunction

    // Memory responder: ok arrives 'lat' cycles after the request is first visible.
    initial begin
        mem_rsp_t r;
        ok_flag_from_memctrl = 1'b0;
        data_from_memctrl    = '0;
        forever begin
            @(negedge clk);
            if (rst && ena_to_memctrl && mem_rsp_q.size() != 0) begin
                r = mem_rsp_q.pop_front();
                repeat (r.lat) @(negedge clk);
                data_from_memctrl    = r.rdata;
                ok_flag_from_memctrl = 1'b1;
                @(negedge clk);
                ok_flag_from_memctrl = 1'b0;
                data_from_memctrl    = $urandom;
            end
        end
    end

    // Memctrl monitor: request fields on the rising edge of ena, stability while held.
    initial begin
        logic     prev;
        bit       stable;
        mem_exp_t cur;
        mem_exp_t e;
        prev   = 1'b0;
        stable = 1'b1;
        forever begin
            @(negedge clk);
            cur = '{rw_flag_to_memctrl, addr_to_memctrl, size_to_memctrl, data_to_memctrl};
            if (ena_to_memctrl && !prev) begin
                if (mem_exp_q.size() == 0) begin
                    check("mem_unexpected_request", 1, 0);
                end else begin
                    e = mem_exp_q.pop_front();
                    check("mem_rw", cur.rw, e.rw);
                    check("mem_addr", cur.addr, e.addr);
                    check("mem_size", cur.size, e.size);
                    if (e.rw) check("mem_wdata", cur.data, e.data);
                end
                stable = 1'b1;
            end else if (ena_to_memctrl && prev) begin
                if (cur != e && !(cur.rw == 1'b0 && cur.addr == e.addr && cur.size == e.size && e.rw == 1'b0))
                    stable = 1'b0;
            end else if (!ena_to_memctrl && prev) begin
                check("mem_held_stable", stable, 1);
            end
            prev = ena_to_memctrl;
        end
    end

    // CDB monitor: each pulse pops one expectation; between pulses the result holds.
    initial begin
        logic [31:0] last_res;
        cdb_exp_t    e;
        last_res = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_res = '0;
            end else if (valid_to_cdb) begin
                if (cdb_q.size() == 0) begin
                    check("cdb_unexpected_pulse", 1, 0);
                    last_res = result_to_cdb;
                end else begin
                    e = cdb_q.pop_front();
                    check("cdb_rob_id", rob_id_to_cdb, e.rob);
                    check("cdb_result", result_to_cdb, e.res);
                    check("cdb_timing", cyc, e.when);
                    last_res = e.res;
                end
            end else begin
                check("cdb_result_hold", result_to_cdb, last_res);
            end
        end
    end

    // Misalign monitor.
    initial begin
        int unsigned w;
        forever begin
            @(negedge clk);
            if (rst && misalign_flag) begin
                if (mis_q.size() == 0) begin
                    check("misalign_unexpected", 1, 0);
                end else begin
                    w = mis_q.pop_front();
                    check("misalign_timing", cyc, w);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_to_lsb && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", busy_to_lsb, 0);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sval,
                         input logic [3:0] rob, input int unsigned lat, input logic [31:0] rdata,
                         input bit flush_now, input bit flush_mid, input bit dbl);
        bit          ld;
        bit          mis;
        bit          acc;
        bit          drop;
        int          b;
        int unsigned n;
        mem_exp_t    me;
        mem_rsp_t    mr;
        cdb_exp_t    ce;
        ld   = is_load(op);
        b    = op_bytes(op);
        mis  = 1'b0;
`ifdef LS_EX_MISALIGN_CHECK_EN
        mis  = (addr % b) != 0;
`endif
        acc  = !(ld && flush_now);
        drop = ld && flush_mid;
        @(negedge clk);
        ena_from_lsb              = 1'b1;
        openum_from_lsb           = op;
        mem_addr_from_lsb         = addr;
        store_value_from_lsb      = sval;
        rob_id_from_lsb           = rob;
        commit_jump_flag_from_rob = flush_now;
        n = cyc + 1;
        if (acc) begin
            if (!mis) begin
                me = '{!ld, addr, 3'(b), ld ? 32'd0 : trunc(sval, b)};
                mr = '{lat, rdata};
                mem_exp_q.push_back(me);
                mem_rsp_q.push_back(mr);
            end else begin
                mis_q.push_back(n);
            end
            if (ld && !drop) begin
                ce = '{rob, mis ? 32'd0 : ext(op, rdata), mis ? n + 1 : n + lat + 1};
                cdb_q.push_back(ce);
            end
        end
        #1 check("busy_same_cycle", busy_to_lsb, 1);
        @(negedge clk);
        if (dbl) begin
            // Protocol violation: a second pulse while the first is in flight.
            openum_from_lsb      = OP_SW;
            mem_addr_from_lsb    = ~addr;
            store_value_from_lsb = ~sval;
            rob_id_from_lsb      = rob + 4'd1;
            commit_jump_flag_from_rob = 1'b0;
            @(negedge clk);
        end
        ena_from_lsb              = 1'b0;
        commit_jump_flag_from_rob = acc ? flush_mid : 1'b0;
        @(negedge clk);
        commit_jump_flag_from_rob = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops[8];
        logic [5:0]  op;
        logic [31:0] a;
        int          b;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        rst                       = 1'b0;
        ena_from_lsb              = 1'b0;
        openum_from_lsb           = '0;
        mem_addr_from_lsb         = '0;
        store_value_from_lsb      = '0;
        rob_id_from_lsb           = '0;
        commit_jump_flag_from_rob = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_to_lsb, 0);
        check("reset_mem_ena", ena_to_memctrl, 0);
        check("reset_cdb_valid", valid_to_cdb, 0);
        check("reset_result", result_to_cdb, 0);
        check("reset_misalign", misalign_flag, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy_low", busy_to_lsb, 0);

        // Directed cases.
        issue(OP_LB,  32'h100, 32'h0, 4'd3, 3, 32'h0000_0080, 0, 0, 0);
        issue(OP_LHU, 32'h102, 32'h0, 4'd4, 2, 32'h0000_F00D, 0, 0, 0);
        issue(OP_LH,  32'h102, 32'h0, 4'd5, 1, 32'h0000_F00D, 0, 0, 0);
        issue(OP_SH,  32'h200, 32'h1234_5678, 4'd6, 3, 32'h0, 0, 0, 0);
        issue(OP_LW,  32'h104, 32'h0, 4'd7, 2, 32'hDEAD_BEEF, 0, 0, 1);
        issue(OP_LW,  32'h108, 32'h0, 4'd8, 4, 32'h1111_2222, 0, 1, 0);
        issue(OP_SW,  32'h10C, 32'hCAFE_F00D, 4'd9, 3, 32'h0, 0, 1, 0);
        issue(OP_LB,  32'h110, 32'h0, 4'd10, 1, 32'h0000_00FF, 1, 0, 0);
        check("flushed_load_no_access", ena_to_memctrl, 0);
        issue(OP_SB,  32'h111, 32'hAAAA_AA5A, 4'd11, 1, 32'h0, 1, 0, 0);
        issue(OP_LBU, 32'h113, 32'h0, 4'd12, 0, 32'h0000_00C3, 0, 0, 0);

        // Asynchronous reset while waiting on memory.
        @(negedge clk);
        ena_from_lsb      = 1'b1;
        openum_from_lsb   = OP_LW;
        mem_addr_from_lsb = 32'h300;
        rob_id_from_lsb   = 4'd5;
        mem_exp_q.push_back('{1'b0, 32'h300, 3'd4, 32'd0});
        mem_rsp_q.push_back('{5, 32'h5555_5555});
        @(negedge clk);
        ena_from_lsb = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_ena", ena_to_memctrl, 0);
        check("arst_rw", rw_flag_to_memctrl, 0);
        check("arst_addr", addr_to_memctrl, 0);
        check("arst_size", size_to_memctrl, 0);
        check("arst_result", result_to_cdb, 0);
        check("arst_busy", busy_to_lsb, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        issue(OP_LH, 32'h302, 32'h0, 4'd13, 2, 32'h0000_7FFF, 0, 0, 0);

`ifdef LS_EX_MISALIGN_CHECK_EN
        issue(OP_LW, 32'h101, 32'h0, 4'd14, 2, 32'h1234_5678, 0, 0, 0);
        issue(OP_LH, 32'h103, 32'h0, 4'd15, 2, 32'h1234_5678, 0, 1, 0);
        issue(OP_SW, 32'h102, 32'h8765_4321, 4'd1, 2, 32'h0, 0, 0, 0);
`endif

        // Randomized traffic, naturally aligned.
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(7)];
            b  = op_bytes(op);
            a  = $urandom;
            a  = (a / b) * b;
            issue(op, a, $urandom, 4'($urandom_range(15, 1)), $urandom_range(4), $urandom,
                  ($urandom_range(9) == 0), ($urandom_range(6) == 0), 0);
        end

        repeat (10) @(negedge clk);
        check("cdb_queue_drained", cdb_q.size(), 0);
        check("mem_queue_drained", mem_exp_q.size(), 0);
        check("misalign_queue_drained", mis_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/ls_ex.md
Name: ls_ex

Overview:
- Load/store execution unit; the receiving end of the load/store buffer's issue interface.
- Accepts one memory request at a time and drives the memory controller (byte/half/word, read/write).
- Sign/zero-extends load data and broadcasts load results on the LS CDB.
- Handles branch-misprediction flush: stores always complete, load results are suppressed.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ROB_ID_W, 4, ROB id width; id 0 means "no entry"
OPENUM_W, 6, width of the shared operation enum (OPENUM_LB..OPENUM_SW from the shared defines)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
ena_from_lsb  in  1  request valid, single-cycle pulse
openum_from_lsb  in  OPENUM_W  LB/LH/LW/LBU/LHU/SB/SH/SW
mem_addr_from_lsb  in  ADDR_W  effective address
store_value_from_lsb  in  DATA_W  store data (low bytes used)
rob_id_from_lsb  in  ROB_ID_W  ROB id of the request
busy_to_lsb  out  1  unit cannot accept a request
ena_to_memctrl  out  1  memory request active
rw_flag_to_memctrl  out  1  0 = read, 1 = write
addr_to_memctrl  out  ADDR_W  access address
size_to_memctrl  out  3  byte count: 1, 2 or 4
data_to_memctrl  out  DATA_W  write data, zero-padded
ok_flag_from_memctrl  in  1  access done, single-cycle pulse
data_from_memctrl  in  DATA_W  read data, right-aligned
commit_jump_flag_from_rob  in  1  misprediction flush
valid_to_cdb  out  1  load result valid, single-cycle pulse
rob_id_to_cdb  out  ROB_ID_W  id of the result
result_to_cdb  out  DATA_W  extended load value
misalign_flag  out  1  misaligned access detected (see Optional Feature)

Behaviour:
- Reset (rst low, async) forces:
  - state IDLE;
  - all outputs 0, except busy_to_lsb, which follows its combinational equation;
  - internal drop flag cleared.
- busy_to_lsb is combinational: (state != IDLE) || ena_from_lsb. This closes the one-cycle window of the buffer's registered issue.
- State IDLE, ena_from_lsb = 1 at edge N:
  - latch openum, addr, store value and rob id;
  - from N+1, drive ena_to_memctrl = 1, rw_flag, addr, size (B = 1, H = 2, W = 4), data masked to size;
  - go to WAIT_MEM.
- State WAIT_MEM:
  - hold all memctrl outputs stable until ok_flag_from_memctrl.
  - On ok at edge M: ena_to_memctrl = 0 at M+1 and state returns to IDLE.
  - Load without drop: valid_to_cdb = 1 for exactly cycle M+1, with rob_id_to_cdb = latched id.
  - Load extension into result_to_cdb: LB = sext of data[7:0], LH = sext of data[15:0], LW = data, LBU/LHU = zero-extend.
  - Stores produce no CDB pulse; result_to_cdb holds its previous value.
- Minimum load latency is request edge to CDB pulse = memory latency + 2 cycles.
- A new request is accepted in the cycle after return to IDLE, never in the ok cycle.
- Flush (commit_jump_flag_from_rob = 1):
  - IDLE with a load arriving the same cycle: the request is ignored (no memory access).
  - IDLE with a store arriving the same cycle: the store is accepted.
  - WAIT_MEM with a load: set drop; the access runs to ok, the CDB pulse is suppressed, drop clears on return to IDLE.
  - WAIT_MEM with a store: no effect.
  - Any cycle: a CDB pulse scheduled for that cycle is still emitted; the ROB discards it.
- ok_flag_from_memctrl in IDLE is ignored.
- An ena_from_lsb pulse while not IDLE is a protocol violation; the pulse is ignored and the latched request is unchanged.

Optional Feature:
- Macro: LS_EX_MISALIGN_CHECK_EN.
- When defined:
  - Misalignment is checked at acceptance: H/HU with addr[0] set, or W with addr[1:0] nonzero.
  - A misaligned request issues no memory access; state goes IDLE -> WAIT_MEM -> IDLE with no memctrl traffic.
  - misalign_flag pulses 1 cycle at N+1.
  - A misaligned load returns result 0 with a CDB pulse at N+2, subject to drop.
- When undefined: misalign_flag is tied to 0 and addresses pass through unchanged.

Test Plan:
- LB at addr 0x100, memctrl returns 0x00000080 after 3 cycles -> single CDB pulse, result 0xFFFFFF80, correct rob id, no second pulse.
- LHU at 0x102, data 0x0000F00D -> result 0x0000F00D; LH with the same data -> 0xFFFFF00D.
- SH value 0x12345678 to 0x200 -> rw = 1, size = 2, data 0x00005678 held stable until ok; no CDB pulse; busy low the cycle after ok.
- Back-to-back pulse: ena_from_lsb at cycle N -> busy_to_lsb high in N (combinational); a second ena at N+1 is ignored.
- Flush mid-LW -> memctrl finishes, valid_to_cdb never rises; a flush mid-SW completes normally; a load arriving with the flush -> ena_to_memctrl stays 0.
- rst pulled low in WAIT_MEM -> all outputs 0 immediately; state IDLE; the next request is accepted normally.
- With LS_EX_MISALIGN_CHECK_EN defined, LW at 0x101 -> no memctrl request, misalign_flag pulse, CDB result 0.
